// File: rtl/pattern_generator.sv
// Memory-game pattern generator: a free-running LFSR appends one bit per round, then the pattern is played back on led.
// Define PATTERN_PLAYBACK_EN to compile in the SHOW/GAP playback; without it a round goes straight from APPEND to DONE.
module pattern_generator #(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          DWELL_CYCLES = 50,
    parameter int          GAP_CYCLES   = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gen_pattern,
    input  logic        clr,
    output logic [15:0] game_pattern,
    output logic [4:0]  pattern_len,
    output logic        led,
    output logic        led_valid,
    output logic        done_gen_pattern,
    output logic        pattern_full
);

    if (SEED == 16'h0000) begin : g_seed_check
        $error("pattern_generator: SEED must be nonzero");
    end
    if (DWELL_CYCLES < 1 || DWELL_CYCLES > 65535) begin : g_dwell_check
        $error("pattern_generator: DWELL_CYCLES out of range 1..65535");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_gap_check
        $error("pattern_generator: GAP_CYCLES out of range 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPEND = 3'd1,
        SHOW   = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q;
    logic        lfsr_fb;
    logic [15:0] pattern_q, pattern_d;
    logic [4:0]  len_q, len_d;
    logic        gen_prev_q;
    logic        req;

    assign req     = gen_pattern & ~gen_prev_q;
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // The LFSR is deliberately outside the clr path so each game draws fresh bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q     <= SEED;
            gen_prev_q <= 1'b0;
            state_q    <= IDLE;
            pattern_q  <= '0;
            len_q      <= '0;
        end else begin
            lfsr_q     <= {lfsr_fb, lfsr_q[15:1]};
            gen_prev_q <= gen_pattern;
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            len_q      <= len_d;
        end
    end

`ifdef PATTERN_PLAYBACK_EN
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end
`endif

    always_comb begin
        state_d          = state_q;
        pattern_d        = pattern_q;
        len_d            = len_q;
        led              = 1'b0;
        led_valid        = 1'b0;
        done_gen_pattern = 1'b0;
`ifdef PATTERN_PLAYBACK_EN
        cnt_d            = cnt_q;
        idx_d            = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = APPEND;
                end
            end
            APPEND: begin
                if (!len_q[4]) begin
                    pattern_d = {pattern_q[14:0], lfsr_q[0]};
                    len_d     = len_q + 5'd1;
                end
`ifdef PATTERN_PLAYBACK_EN
                // Playback starts from the oldest bit, i.e. index new_len-1.
                idx_d   = len_q[4] ? 4'd15 : len_q[3:0];
                cnt_d   = '0;
                state_d = SHOW;
`else
                state_d = DONE;
`endif
            end
`ifdef PATTERN_PLAYBACK_EN
            SHOW: begin
                led       = pattern_q[idx_q];
                led_valid = 1'b1;
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q - 4'd1;
                        state_d = SHOW;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            DONE: begin
                done_gen_pattern = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New-game clear overrides everything, including a same-cycle request.
        if (clr) begin
            state_d   = IDLE;
            pattern_d = '0;
            len_d     = '0;
`ifdef PATTERN_PLAYBACK_EN
            cnt_d     = '0;
            idx_d     = '0;
`endif
        end
    end

    assign game_pattern = pattern_q;
    assign pattern_len  = len_q;
    assign pattern_full = (len_q == 5'd16);

endmodule

// File: tb/tb_pattern_generator.sv
// Randomized self-checking bench for pattern_generator with a timing/pattern model derived from round arithmetic.
module tb_pattern_generator;

    localparam int          D    = 2;
    localparam int          G    = 1;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef PATTERN_PLAYBACK_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gen_pattern = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] game_pattern;
    logic [4:0]  pattern_len;
    logic        led;
    logic        led_valid;
    logic        done_gen_pattern;
    logic        pattern_full;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;
    logic [15:0] m_pat = '0;
    int          m_len = 0;

    pattern_generator #(
        .SEED         (SEED),
        .DWELL_CYCLES (D),
        .GAP_CYCLES   (G)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .gen_pattern      (gen_pattern),
        .clr              (clr),
        .game_pattern     (game_pattern),
        .pattern_len      (pattern_len),
        .led              (led),
        .led_valid        (led_valid),
        .done_gen_pattern (done_gen_pattern),
        .pattern_full     (pattern_full)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    // Reference LFSR: free-running from SEED whenever out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int span(input int n);
        return PB * n * (D + G);
    endfunction

    function automatic logic exp_valid(input int k, input int n);
        int p;
        p = k - 2;
        if (p < 0 || p >= span(n)) return 1'b0;
        return (p % (D + G)) < D;
    endfunction

    function automatic logic exp_led(input int k, input int n, input logic [15:0] pat);
        int p;
        p = k - 2;
        if (!exp_valid(k, n)) return 1'b0;
        return pat[n - 1 - p / (D + G)];
    endfunction

    task automatic idle_gap();
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    task automatic clear_game();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_pat = '0;
        m_len = 0;
        check_eq("clr_pattern", 32'(game_pattern), 32'h0);
        check_eq("clr_len", 32'(pattern_len), 32'h0);
        $display("clear: len=%0d pattern=%04h", pattern_len, game_pattern);
    endtask

    // One round from a rising edge of gen_pattern; k counts cycles after the request cycle.
    task automatic do_round(input bit hold, input bit toggle, input int clr_at);
        int          n, dk, last, lower_k;
        logic [15:0] pat_before;
        bit          cleared;
        cleared = 1'b0;
        @(negedge clk);
        gen_pattern = 1'b1;
        pat_before = m_pat;
        n       = (m_len < 16) ? m_len + 1 : 16;
        dk      = 2 + span(n);
        lower_k = hold ? dk + 4 : int'($urandom_range(1, 2));
        last    = hold ? dk + 4 : dk + 1;
        if (clr_at >= 0) last = dk + 2;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == lower_k) gen_pattern = 1'b0;
            if (toggle && PB == 1) begin
                if (k == 3) gen_pattern = 1'b0;
                if (k == 4) gen_pattern = 1'b1;
                if (k == 5) gen_pattern = 1'b0;
            end
            if (k == 1) begin
                check_eq("pattern_before_append", 32'(game_pattern), 32'(pat_before));
                if (m_len < 16) begin
                    m_pat = {m_pat[14:0], m_lfsr[0]};
                    m_len++;
                end
            end
            if (clr_at >= 0 && k == clr_at + 1) begin
                clr = 1'b0;
                cleared = 1'b1;
                m_pat = '0;
                m_len = 0;
                check_eq("clr_mid_pattern", 32'(game_pattern), 32'h0);
                check_eq("clr_mid_len", 32'(pattern_len), 32'h0);
                check_eq("clr_mid_led", 32'(led), 32'h0);
                check_eq("clr_mid_led_valid", 32'(led_valid), 32'h0);
            end
            if (cleared) begin
                check_eq("clr_no_done", 32'(done_gen_pattern), 32'h0);
                check_eq("clr_no_led_valid", 32'(led_valid), 32'h0);
            end else begin
                if (k == 2) begin
                    check_eq("pattern", 32'(game_pattern), 32'(m_pat));
                    check_eq("len", 32'(pattern_len), 32'(m_len));
                    check_eq("full", 32'(pattern_full), 32'(m_len == 16));
                end
                if (k < dk) begin
                    check_eq("led_valid", 32'(led_valid), 32'(exp_valid(k, n)));
                    check_eq("led", 32'(led), 32'(exp_led(k, n, m_pat)));
                    check_eq("done_early", 32'(done_gen_pattern), 32'h0);
                end else if (k == dk) begin
                    check_eq("done", 32'(done_gen_pattern), 32'h1);
                    check_eq("led_valid_at_done", 32'(led_valid), 32'h0);
                end else begin
                    check_eq("done_after", 32'(done_gen_pattern), 32'h0);
                    check_eq("led_valid_after", 32'(led_valid), 32'h0);
                    check_eq("len_after", 32'(pattern_len), 32'(m_len));
                end
            end
            if (clr_at >= 0 && k == clr_at) clr = 1'b1;
        end
        gen_pattern = 1'b0;
        $display("round: len=%0d pattern=%04h done_at=t+%0d hold=%0d toggle=%0d clr_at=%0d",
                 pattern_len, game_pattern, dk, hold, toggle, clr_at);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check_eq("rst_pattern", 32'(game_pattern), 32'h0);
        check_eq("rst_len", 32'(pattern_len), 32'h0);
        check_eq("rst_led", 32'(led), 32'h0);
        check_eq("rst_led_valid", 32'(led_valid), 32'h0);
        check_eq("rst_done", 32'(done_gen_pattern), 32'h0);
        check_eq("rst_full", 32'(pattern_full), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_gap();

        // First round, then two more
        do_round(1'b0, 1'b0, -1);
        for (int r = 0; r < 2; r++) begin
            idle_gap();
            do_round(1'b0, 1'b0, -1);
        end
        check_eq("len_three", 32'(pattern_len), 32'd3);

        // Clear mid-playback of round 2 of a new game
        clear_game();
        idle_gap();
        do_round(1'b0, 1'b0, -1);
        idle_gap();
        do_round(1'b0, 1'b0, (PB == 1) ? int'($urandom_range(2, 1 + D)) : 1);

        // Request held across done, and re-toggled during playback
        idle_gap();
        do_round(1'b1, 1'b0, -1);
        idle_gap();
        do_round(1'b0, 1'b1, -1);
        check_eq("len_one_per_edge", 32'(pattern_len), 32'd2);

        // Seventeen rounds from empty: saturation at 16
        clear_game();
        for (int r = 0; r < 17; r++) begin
            idle_gap();
            do_round(1'b0, 1'b0, -1);
        end
        check_eq("sat_len", 32'(pattern_len), 32'd16);
        check_eq("sat_full", 32'(pattern_full), 32'h1);

        // Clear and request in the same cycle: clear wins
        idle_gap();
        @(negedge clk);
        gen_pattern = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        gen_pattern = 1'b0;
        m_pat = '0;
        m_len = 0;
        check_eq("clrreq_len", 32'(pattern_len), 32'h0);
        check_eq("clrreq_full", 32'(pattern_full), 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("clrreq_no_done", 32'(done_gen_pattern), 32'h0);
            check_eq("clrreq_no_show", 32'(led_valid), 32'h0);
            check_eq("clrreq_len_hold", 32'(pattern_len), 32'h0);
        end
        $display("clr+request: len=%0d pattern=%04h", pattern_len, game_pattern);

        // Asynchronous reset in the middle of a round
        idle_gap();
        do_round(1'b0, 1'b0, -1);
        idle_gap();
        @(negedge clk);
        gen_pattern = 1'b1;
        @(negedge clk);
        gen_pattern = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_pat = '0;
        m_len = 0;
        check_eq("arst_pattern", 32'(game_pattern), 32'h0);
        check_eq("arst_len", 32'(pattern_len), 32'h0);
        check_eq("arst_led", 32'(led), 32'h0);
        check_eq("arst_led_valid", 32'(led_valid), 32'h0);
        check_eq("arst_done", 32'(done_gen_pattern), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_eq("arst_no_done", 32'(done_gen_pattern), 32'h0);
            check_eq("arst_no_show", 32'(led_valid), 32'h0);
        end
        $display("async reset: len=%0d pattern=%04h", pattern_len, game_pattern);

        // After reset the generator must work again from SEED
        idle_gap();
        do_round(1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
